// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the memory/writeback stage of the GPU core:
//   - writeback-source select encodings seen by the downstream 3:1 mux
//   - stage state encoding
//   - helper that derives the register-file write enable from a bundle
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

    // Writeback-source select encodings (wb_sel)
    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_PC4  = 2'b10;
    localparam logic [1:0] WB_SRC_RSVD = 2'b11;

    // Stage state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // The reserved select has no mux input behind it, so a write through it
    // would commit garbage; the select is still passed through for visibility.
    function automatic logic wb_write_en(input logic reg_we, input logic [1:0] sel);
        return reg_we && (sel != WB_SRC_RSVD);
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory/writeback pipeline stage. Accepts one execute bundle per valid/ready
// handshake, optionally performs a data-memory load or store over a
// req/gnt/rvalid interface, and presents a registered writeback bundle with a
// single-cycle wb_valid pulse to the downstream writeback-select mux.
//
// Parameters:
//   DWIDTH  data width (ALU result, store data, load data, PC+4)
//   AWIDTH  memory address width, taken from the low bits of the ALU result
//           (must not exceed DWIDTH)
//   RWIDTH  destination register index width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid / ex_ready      execute-bundle handshake
//   ex_alu_result            ALU result / memory address
//   ex_store_data            store data
//   ex_pc_plus4              link value
//   ex_rd, ex_reg_we         destination register and write enable
//   ex_mem_rd, ex_mem_wr     load / store request (load wins when both set)
//   ex_wb_sel                writeback source select
//   dmem_req/we/addr/wdata   data-memory request (held stable until gnt)
//   dmem_gnt                 request accepted
//   dmem_rvalid, dmem_rdata  load response
//   wb_valid                 one-cycle writeback pulse
//   wb_alu, wb_mem, wb_pc4   writeback mux inputs A/B/C
//   wb_sel, wb_rd, wb_we     mux select, destination, qualified write enable
// -----------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DWIDTH-1:0] ex_alu_result,
    input  logic [DWIDTH-1:0] ex_store_data,
    input  logic [DWIDTH-1:0] ex_pc_plus4,
    input  logic [RWIDTH-1:0] ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [1:0]        ex_wb_sel,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DWIDTH-1:0] dmem_rdata,

    output logic              wb_valid,
    output logic [DWIDTH-1:0] wb_alu,
    output logic [DWIDTH-1:0] wb_mem,
    output logic [DWIDTH-1:0] wb_pc4,
    output logic [1:0]        wb_sel,
    output logic [RWIDTH-1:0] wb_rd,
    output logic              wb_we
);

    // Stage control state
    state_e              state_q,      state_d;

    // Memory request registers
    logic                dmem_req_q,   dmem_req_d;
    logic                dmem_we_q,    dmem_we_d;
    logic [AWIDTH-1:0]   dmem_addr_q,  dmem_addr_d;
    logic [DWIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;

    // Writeback registers
    logic                wb_valid_q,   wb_valid_d;
    logic                wb_we_q,      wb_we_d;
    logic [DWIDTH-1:0]   wb_alu_q,     wb_alu_d;
    logic [DWIDTH-1:0]   wb_mem_q,     wb_mem_d;
    logic [DWIDTH-1:0]   wb_pc4_q,     wb_pc4_d;
    logic [1:0]          wb_sel_q,     wb_sel_d;
    logic [RWIDTH-1:0]   wb_rd_q,      wb_rd_d;

    // Bundle parked while a memory op is outstanding; the wb_* registers keep
    // showing the previous writeback until the memory op completes.
    logic [DWIDTH-1:0]   cap_alu_q,    cap_alu_d;
    logic [DWIDTH-1:0]   cap_pc4_q,    cap_pc4_d;
    logic [1:0]          cap_sel_q,    cap_sel_d;
    logic [RWIDTH-1:0]   cap_rd_q,     cap_rd_d;
    logic                cap_we_q,     cap_we_d;

    logic                complete;
    logic                load_done;
    logic                accept;

    // Ready depends only on state and reset so it never loops back through
    // the producer's valid.
    assign ex_ready = (state_q == IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_alu_d     = wb_alu_q;
        wb_mem_d     = wb_mem_q;
        wb_pc4_d     = wb_pc4_q;
        wb_sel_d     = wb_sel_q;
        wb_rd_d      = wb_rd_q;
        cap_alu_d    = cap_alu_q;
        cap_pc4_d    = cap_pc4_q;
        cap_sel_d    = cap_sel_q;
        cap_rd_d     = cap_rd_q;
        cap_we_d     = cap_we_q;
        complete     = 1'b0;
        load_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_mem_rd || ex_mem_wr) begin
                        cap_alu_d    = ex_alu_result;
                        cap_pc4_d    = ex_pc_plus4;
                        cap_sel_d    = ex_wb_sel;
                        cap_rd_d     = ex_rd;
                        cap_we_d     = wb_write_en(ex_reg_we, ex_wb_sel);
                        dmem_req_d   = 1'b1;
                        // Load takes priority when both op flags are set.
                        dmem_we_d    = !ex_mem_rd;
                        dmem_addr_d  = ex_alu_result[AWIDTH-1:0];
                        dmem_wdata_d = ex_store_data;
                        state_d      = REQ;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = wb_write_en(ex_reg_we, ex_wb_sel);
                        wb_alu_d   = ex_alu_result;
                        wb_pc4_d   = ex_pc_plus4;
                        wb_sel_d   = ex_wb_sel;
                        wb_rd_d    = ex_rd;
                    end
                end
            end
            REQ: begin
                // rvalid is only meaningful from the grant cycle onwards.
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (dmem_we_q) begin
                        complete = 1'b1;
                    end else if (dmem_rvalid) begin
                        complete  = 1'b1;
                        load_done = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    complete  = 1'b1;
                    load_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = cap_we_q;
            wb_alu_d   = cap_alu_q;
            wb_pc4_d   = cap_pc4_q;
            wb_sel_d   = cap_sel_q;
            wb_rd_d    = cap_rd_q;
        end
        if (load_done) begin
            wb_mem_d = dmem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_alu_q     <= '0;
            wb_mem_q     <= '0;
            wb_pc4_q     <= '0;
            wb_sel_q     <= '0;
            wb_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_alu_q     <= wb_alu_d;
            wb_mem_q     <= wb_mem_d;
            wb_pc4_q     <= wb_pc4_d;
            wb_sel_q     <= wb_sel_d;
            wb_rd_q      <= wb_rd_d;
        end
    end

    // Parked bundle is only read after it has been written on acceptance,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        cap_alu_q <= cap_alu_d;
        cap_pc4_q <= cap_pc4_d;
        cap_sel_q <= cap_sel_d;
        cap_rd_q  <= cap_rd_d;
        cap_we_q  <= cap_we_d;
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_alu     = wb_alu_q;
    assign wb_mem     = wb_mem_q;
    assign wb_pc4     = wb_pc4_q;
    assign wb_sel     = wb_sel_q;
    assign wb_rd      = wb_rd_q;

endmodule
